// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and defaults for the SAR conversion controller
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONV,
    DONE
  } sar_state_t;

  localparam int DEF_NBIT          = 8;
  localparam int DEF_SAMPLE_CYCLES = 2;
  localparam int CNT_W             = $clog2(16);

endpackage

// File: rtl/sar_bit_ptr.sv
// rtl/sar_bit_ptr.sv - one-hot pointer to the bit currently under trial
module sar_bit_ptr #(
  parameter int NBIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  output logic [NBIT-1:0] ptr,
  output logic            last
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= {1'b1, {(NBIT-1){1'b0}}};
    end else if (shift) begin
      ptr <= ptr >> 1;
    end
  end

  assign last = ptr[0];

endmodule

// File: rtl/sar_logic.sv
// rtl/sar_logic.sv - SAR controller: track/hold sequencing, MSB-first bit search, result strobe
module sar_logic
  import sar_pkg::*;
#(
  parameter int NBIT          = DEF_NBIT,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cmp,
  output logic            sample,
  output logic [NBIT-1:0] dac_code,
  output logic            busy,
  output logic [NBIT-1:0] code,
  output logic            valid
);

  localparam logic [NBIT-1:0]  MSB_CODE = {1'b1, {(NBIT-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SAMPLE_CYCLES - 1);

  sar_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [NBIT-1:0]  ptr;
  logic             ptr_last;
  logic             ptr_load;
  logic             ptr_shift;
  logic [NBIT-1:0]  trial_next;

  assign ptr_load  = (state == SAMPLE) && (cnt == '0);
  assign ptr_shift = (state == CONV);

  sar_bit_ptr #(.NBIT(NBIT)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .load  (ptr_load),
    .shift (ptr_shift),
    .ptr   (ptr),
    .last  (ptr_last)
  );

  // Resolve the current bit from cmp and raise the next-lower trial bit.
  always_comb begin
    trial_next = (dac_code & ~ptr) | (cmp ? ptr : '0) | (ptr >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      sample   <= 1'b0;
      dac_code <= '0;
      busy     <= 1'b0;
      code     <= '0;
      valid    <= 1'b0;
      cnt      <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SAMPLE;
            sample <= 1'b1;
            busy   <= 1'b1;
            cnt    <= CNT_LOAD;
          end
        end
        SAMPLE: begin
          if (cnt == '0) begin
            state    <= CONV;
            sample   <= 1'b0;
            dac_code <= MSB_CODE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CONV: begin
          dac_code <= trial_next;
          if (ptr_last) begin
            state <= DONE;
            code  <= trial_next;
            valid <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          if (start) begin
            state  <= SAMPLE;
            sample <= 1'b1;
            busy   <= 1'b1;
            cnt    <= CNT_LOAD;
          end else begin
            state    <= IDLE;
            dac_code <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_logic.sv
// tb/tb_sar_logic.sv - directed vector bench for sar_logic (8-bit default and 12-bit instances)
module tb_sar_logic;
  import sar_pkg::*;

  logic        clk = 1'b0;
  logic        rst8, start8, cmp8, sample8, busy8, valid8;
  logic [7:0]  dac8, code8, vin8;
  logic [1:0]  mode8;
  logic        rst12, start12, cmp12, sample12, busy12, valid12;
  logic [11:0] dac12, code12, vin12;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Comparator model: mode 0 compares held input, 1 ties high, 2 ties low.
  assign cmp8  = (mode8 == 2'd1) ? 1'b1 : (mode8 == 2'd2) ? 1'b0 : (vin8 >= dac8);
  assign cmp12 = (vin12 >= dac12);

  sar_logic u8 (
    .clk(clk), .rst(rst8), .start(start8), .cmp(cmp8), .sample(sample8),
    .dac_code(dac8), .busy(busy8), .code(code8), .valid(valid8)
  );

  sar_logic #(.NBIT(12), .SAMPLE_CYCLES(1)) u12 (
    .clk(clk), .rst(rst12), .start(start12), .cmp(cmp12), .sample(sample12),
    .dac_code(dac12), .busy(busy12), .code(code12), .valid(valid12)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] v;
    logic [1:0] mode;
    logic [7:0] exp_code;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] seq8 [8];
  logic [7:0] res_code;
  int         res_lat, res_nval, res_samp;

  // One 8-bit conversion; start pulsed once, optionally re-pulsed in SAMPLE and CONV.
  task automatic conv8(input logic [7:0] v, input logic [1:0] mode, input bit repulse);
    res_lat = 0; res_nval = 0; res_samp = 0; res_code = 'x;
    vin8 = v; mode8 = mode;
    @(negedge clk);
    start8 = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (sample8) res_samp++;
      if (n >= 3 && n <= 10) seq8[n-3] = dac8;
      if (valid8) begin
        res_nval++;
        if (res_nval == 1) begin
          res_lat  = n;
          res_code = code8;
        end
      end
      start8 = repulse && (n == 2 || n == 6);
    end
  endtask

  logic [7:0] a5_seq [8];
  logic [7:0] acc, trial;
  bit         keep;
  bit         bad;
  int         nval;

  initial begin
    tbl[0] = '{8'hA5, 2'd0, 8'hA5};
    tbl[1] = '{8'h00, 2'd1, 8'hFF};
    tbl[2] = '{8'hFF, 2'd2, 8'h00};
    tbl[3] = '{8'h00, 2'd0, 8'h00};
    tbl[4] = '{8'hFF, 2'd0, 8'hFF};
    tbl[5] = '{8'h80, 2'd0, 8'h80};
    tbl[6] = '{8'h7F, 2'd0, 8'h7F};
    tbl[7] = '{8'h01, 2'd0, 8'h01};
    a5_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    rst8 = 1'b0; start8 = 1'b0; vin8 = 8'h00; mode8 = 2'd0;
    rst12 = 1'b0; start12 = 1'b0; vin12 = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {sample8, busy8, valid8, dac8, code8}, 32'h0);
    rst8 = 1'b1; rst12 = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if ({sample8, busy8, valid8, dac8, code8} != 0 || u8.state != IDLE) bad = 1'b1;
    end
    chk("idle_20_cycles", {31'd0, bad}, 32'd0);

    for (int t = 0; t < 8; t++) begin
      conv8(tbl[t].v, tbl[t].mode, 1'b0);
      chk($sformatf("v%0d_code", t), {24'd0, res_code}, {24'd0, tbl[t].exp_code});
      chk($sformatf("v%0d_latency", t), res_lat, 11);
      chk($sformatf("v%0d_nvalid", t), res_nval, 1);
      chk($sformatf("v%0d_sample_cycles", t), res_samp, 2);
      acc = 8'h00;
      for (int i = 0; i < 8; i++) begin
        trial = acc | (8'h80 >> i);
        chk($sformatf("v%0d_dac_%0d", t, i), {24'd0, seq8[i]}, {24'd0, trial});
        keep = (tbl[t].mode == 2'd1) ? 1'b1 : (tbl[t].mode == 2'd2) ? 1'b0 : (tbl[t].v >= trial);
        if (keep) acc = trial;
      end
      chk($sformatf("v%0d_code_held", t), {24'd0, code8}, {24'd0, tbl[t].exp_code});
      chk($sformatf("v%0d_dac_idle", t), {24'd0, dac8}, 32'h0);
    end

    conv8(8'hA5, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("a5_seq_%0d", i), {24'd0, seq8[i]}, {24'd0, a5_seq[i]});

    conv8(8'h5A, 2'd0, 1'b1);
    chk("repulse_nvalid", res_nval, 1);
    chk("repulse_code", {24'd0, res_code}, 32'h5A);
    chk("repulse_latency", res_lat, 11);

    // Back-to-back with start held high.
    vin8 = 8'h3C; mode8 = 2'd0;
    @(negedge clk);
    start8 = 1'b1;
    nval = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 11) begin
        chk("b2b_valid1", {31'd0, valid8}, 32'd1);
        chk("b2b_code1", {24'd0, code8}, 32'h3C);
        vin8 = 8'hC3;
      end
      if (n == 12) begin
        chk("b2b_sample_rerise", {31'd0, sample8}, 32'd1);
        start8 = 1'b0;
      end
      if (n == 22) begin
        chk("b2b_valid2", {31'd0, valid8}, 32'd1);
        chk("b2b_code2", {24'd0, code8}, 32'hC3);
      end
      if (valid8) nval++;
    end
    chk("b2b_nvalid", nval, 2);

    // Reset at the 4th CONV cycle aborts the conversion.
    vin8 = 8'h96;
    @(negedge clk);
    start8 = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
    end
    chk("abort_in_conv", {31'd0, u8.state == CONV}, 32'd1);
    rst8 = 1'b0;
    @(posedge clk); #1;
    chk("abort_outputs", {sample8, busy8, valid8, dac8, code8}, 32'h0);
    rst8 = 1'b1;
    nval = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (valid8) nval++;
    end
    chk("abort_no_valid", nval, 0);
    conv8(8'h96, 2'd0, 1'b0);
    chk("post_abort_code", {24'd0, res_code}, 32'h96);
    chk("post_abort_latency", res_lat, 11);

    // 12-bit instance, one sample cycle.
    vin12 = 12'h801;
    @(negedge clk);
    start12 = 1'b1;
    nval = 0;
    res_lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      start12 = 1'b0;
      if (n == 1) chk("n12_sample", {31'd0, sample12}, 32'd1);
      if (n == 2) chk("n12_msb_trial", {20'd0, dac12}, 32'h800);
      if (valid12) begin
        nval++;
        if (nval == 1) begin
          res_lat = n;
          chk("n12_code", {20'd0, code12}, 32'h801);
        end
      end
    end
    chk("n12_latency", res_lat, 14);
    chk("n12_nvalid", nval, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
